// File: rtl/mux_2to1.sv
// -----------------------------------------------------------------------------
// mux_2to1
//   Parameterised 2-to-1 data multiplexer with a small clocked status section.
//   mux_out forwards din_1 when sel is high and din_0 otherwise. The clocked
//   logic detects changes of the sampled select and counts them for debug.
//
//   Optional feature macro: MUX_2TO1_REG_OUT_EN
//     defined   -> mux_out comes from a WIDTH-bit register (1-cycle latency,
//                  cleared to 0 by rst_n)
//     undefined -> mux_out is purely combinational (default build)
//
// Parameters
//   WIDTH     : data width of din_0, din_1 and mux_out
//   CNT_WIDTH : width of the select-switch counter sw_cnt
//
// Ports
//   mux_out [WIDTH]     out : selected data
//   din_0   [WIDTH]     in  : data selected when sel = 0
//   din_1   [WIDTH]     in  : data selected when sel = 1
//   sel                 in  : select
//   clk                 in  : rising-edge clock
//   rst_n               in  : asynchronous active-low reset
//   sel_chg             out : one-cycle pulse when sampled sel differs from the
//                             previous sample
//   sw_cnt  [CNT_WIDTH] out : detected select changes since reset (wraps)
// -----------------------------------------------------------------------------
module mux_2to1 #(
  parameter int WIDTH     = 1,
  parameter int CNT_WIDTH = 16
) (
  output logic [WIDTH-1:0]     mux_out,
  input  logic [WIDTH-1:0]     din_0,
  input  logic [WIDTH-1:0]     din_1,
  input  logic                 sel,
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 sel_chg,
  output logic [CNT_WIDTH-1:0] sw_cnt
);

  // Selected data, built bit by bit. An X/Z on sel propagates per the
  // ternary rules of the language; nothing resolves it.
  logic [WIDTH-1:0] mux_next;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit_mux
      assign mux_next[gi] = sel ? din_1[gi] : din_0[gi];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------
`ifdef MUX_2TO1_REG_OUT_EN
  logic [WIDTH-1:0] mux_out_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mux_out_reg <= '0;
    end else begin
      mux_out_reg <= mux_next;
    end
  end

  assign mux_out = mux_out_reg;
`else
  // Combinational path: tracks the inputs even while reset is asserted.
  assign mux_out = mux_next;
`endif

  // ---------------------------------------------------------------------------
  // Select change detection and switch counter
  // ---------------------------------------------------------------------------
  logic                 sel_q_reg;
  logic                 sel_chg_reg;
  logic [CNT_WIDTH-1:0] sw_cnt_reg;
  logic                 sel_diff;

  // sel_q_reg resets to 0, so a sel held high through reset release is seen
  // as a change on the first sampling edge.
  assign sel_diff = sel ^ sel_q_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q_reg   <= 1'b0;
      sel_chg_reg <= 1'b0;
      sw_cnt_reg  <= '0;
    end else begin
      sel_q_reg   <= sel;
      sel_chg_reg <= sel_diff;
      // Free-running wrap: all-ones rolls over to zero.
      if (sel_diff) begin
        sw_cnt_reg <= sw_cnt_reg + CNT_WIDTH'(1);
      end
    end
  end

  assign sel_chg = sel_chg_reg;
  assign sw_cnt  = sw_cnt_reg;

endmodule

// File: tb/tb_mux_2to1.sv
// -----------------------------------------------------------------------------
// tb_mux_2to1
//   Self-checking bench for mux_2to1 (WIDTH = 8, CNT_WIDTH = 4). Expected
//   values come from a reference model that keeps the history of sampled
//   select values and derives change pulses and counts from that history.
// -----------------------------------------------------------------------------
module tb_mux_2to1;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sel;
  logic [W-1:0]  din_0;
  logic [W-1:0]  din_1;
  logic [W-1:0]  mux_out;
  logic          sel_chg;
  logic [CW-1:0] sw_cnt;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  mux_2to1 #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .mux_out (mux_out),
    .din_0   (din_0),
    .din_1   (din_1),
    .sel     (sel),
    .clk     (clk),
    .rst_n   (rst_n),
    .sel_chg (sel_chg),
    .sw_cnt  (sw_cnt)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: history of sel values seen at each rising edge since the
  // last reset. Entry 0 stands for the reset state (select considered low).
  // ---------------------------------------------------------------------------
  int           hist[$] = '{0};
  logic [W-1:0] exp_reg_mux = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist        = '{0};
      exp_reg_mux = '0;
    end else begin
      hist.push_back(sel ? 1 : 0);
      exp_reg_mux = sel ? din_1 : din_0;
    end
  end

  function automatic int exp_cnt();
    int n = 0;
    for (int i = 1; i < hist.size(); i++)
      if (hist[i] != hist[i-1]) n++;
    return n % (1 << CW);
  endfunction

  function automatic logic exp_chg();
    if (hist.size() < 2) return 1'b0;
    return hist[hist.size()-1] != hist[hist.size()-2];
  endfunction

  function automatic logic [W-1:0] exp_mux();
`ifdef MUX_2TO1_REG_OUT_EN
    return exp_reg_mux;
`else
    return (din_1 & {W{sel}}) | (din_0 & ~{W{sel}});
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: let the rising edge happen, then compare on the falling
  // edge where nothing is changing.
  task automatic cycle(input string tag);
    @(negedge clk);
    if (sel_chg === 1'b1) pulses++;
    check({tag, "_chg"}, 32'(sel_chg), 32'(exp_chg()));
    check({tag, "_cnt"}, 32'(sw_cnt), 32'(exp_cnt()));
    check({tag, "_mux"}, 32'(mux_out), 32'(exp_mux()));
    $display("cycle %s sel=%0b d0=%02h d1=%02h mux=%02h chg=%0b cnt=%0d",
             tag, sel, din_0, din_1, mux_out, sel_chg, sw_cnt);
  endtask

  initial begin
    // ---------------- reset state -----------------------------------------
    rst_n = 1'b0;
    sel   = 1'b0;
    din_0 = 8'h00;
    din_1 = 8'h01;
    #2;
    check("rst_chg", 32'(sel_chg), 32'd0);
    check("rst_cnt", 32'(sw_cnt), 32'd0);
    check("rst_mux", 32'(mux_out), 32'(exp_mux()));

    // ---------------- data path, sel toggling every 5 time units ------------
    // Changes land at t = 2, 7, 12, ... and never on a clock edge.
    for (int i = 0; i < 12; i++) begin
      if (i == 4) begin din_0 = 8'h01; din_1 = 8'h00; end
      if (i == 8) begin din_0 = 8'h00; din_1 = 8'h01; end
      sel = i[0];
      #1;
      check("comb_mux", 32'(mux_out), 32'(exp_mux()));
      $display("comb step %0d sel=%0b d0=%0h d1=%0h mux=%0h", i, sel, din_0, din_1, mux_out);
      #4;
    end

    // ---------------- release with sel high -------------------------------
    @(negedge clk);
    sel    = 1'b1;
    rst_n  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 3; i++) cycle("release");
    check("release_pulses", 32'(pulses), 32'd1);
    check("release_cnt1", 32'(sw_cnt), 32'd1);

    // ---------------- four slow toggles ------------------------------------
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      sel = ~sel;
      for (int i = 0; i < 3; i++) cycle("toggle");
    end
    check("toggle_pulses", 32'(pulses), 32'd4);
    check("toggle_cnt5", 32'(sw_cnt), 32'd5);

    // ---------------- wrap at 16 changes -----------------------------------
    for (int k = 0; k < 11; k++) begin
      sel = ~sel;
      for (int i = 0; i < 2; i++) cycle("wrap");
    end
    check("wrap_cnt0", 32'(sw_cnt), 32'd0);

    // ---------------- randomized traffic -----------------------------------
    for (int i = 0; i < 60; i++) begin
      sel   = 1'($urandom_range(0, 1));
      din_0 = 8'($urandom);
      din_1 = 8'($urandom);
      #1;
      check("rand_mux_now", 32'(mux_out), 32'(exp_mux()));
      cycle("rand");
    end

    // ---------------- asynchronous reset mid-count -------------------------
    sel = 1'b0;
    cycle("pre_rst");
    sel = 1'b1;
    cycle("pre_rst");          // sel_chg high, sel_q high at this point
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_cnt", 32'(sw_cnt), 32'd0);
    check("arst_chg", 32'(sel_chg), 32'd0);
    check("arst_selq", 32'(dut.sel_q_reg), 32'd0);
    check("arst_mux", 32'(mux_out), 32'(exp_mux()));
    cycle("in_rst");
    cycle("in_rst");
    sel   = 1'b0;
    rst_n = 1'b1;
    cycle("post_rst");
    cycle("post_rst");

    // ---------------- simultaneous sel and data change ---------------------
    din_0 = 8'hA5;
    din_1 = 8'h3C;
    sel   = 1'b0;
    cycle("simul");
    sel   = 1'b1;
    din_1 = 8'hFF;
    #1;
    check("simul_now", 32'(mux_out), 32'(exp_mux()));
    cycle("simul");
    cycle("simul");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
